// File: rtl/ahb_arb_pkg.sv
// Shared AHB arbiter definitions: transfer/burst codes, FSM states and burst-length decode.
// Used by ahb_bus_arbiter (optional ARB_ROUND_ROBIN_EN) and ahb_arb_pick.
package ahb_arb_pkg;

    localparam int IDX_W  = 2;
    localparam int BEAT_W = 5;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    typedef enum logic [1:0] {
        ST_PARK = 2'd0,
        ST_OWN  = 2'd1,
        ST_LOCK = 2'd2
    } arb_state_e;

    // Remaining beats after the NONSEQ one; undefined-length INCR counts as a single beat.
    function automatic logic [BEAT_W-1:0] burst_beats(input logic [2:0] hburst);
        logic [BEAT_W-1:0] beats;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  beats = BEAT_W'(3);
            HBURST_WRAP8,  HBURST_INCR8:  beats = BEAT_W'(7);
            HBURST_WRAP16, HBURST_INCR16: beats = BEAT_W'(15);
            default:                      beats = '0;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_arb_pick.sv
// Combinational winner search: first requester found walking upward from start_i, wrapping
// modulo NUM_MST. A start of zero gives plain lowest-index priority.
module ahb_arb_pick
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MST = 4
) (
    input  logic [NUM_MST-1:0] req_i,
    input  logic [IDX_W-1:0]   start_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               valid_o
);

    logic [IDX_W-1:0]   cand_idx [NUM_MST];
    logic [NUM_MST-1:0] cand_req;

    for (genvar gi = 0; gi < NUM_MST; gi++) begin : g_cand
        logic [IDX_W:0] sum;
        assign sum           = {1'b0, start_i} + (IDX_W+1)'(gi);
        assign cand_idx[gi]  = (sum >= (IDX_W+1)'(NUM_MST)) ? IDX_W'(sum - (IDX_W+1)'(NUM_MST))
                                                             : sum[IDX_W-1:0];
        assign cand_req[gi]  = req_i[cand_idx[gi]];
    end

    // Walk from the far end so the nearest candidate to start_i is written last.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        for (int i = NUM_MST - 1; i >= 0; i--) begin
            if (cand_req[i]) begin
                winner_o = cand_idx[i];
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter for up to four masters: burst-aware rearbitration, locked sequences, parking.
// Define ARB_ROUND_ROBIN_EN for round-robin selection; fixed lowest-index priority otherwise.
module ahb_bus_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MST = 4,
    parameter int DEF_MST = 0
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic [NUM_MST-1:0] HBUSREQ,
    input  logic [NUM_MST-1:0] HLOCK,
    input  logic [1:0]         HTRANS,
    input  logic [2:0]         HBURST,
    input  logic               HREADY,
    output logic [NUM_MST-1:0] HGRANT,
    output logic [3:0]         HMASTER,
    output logic               HMASTLOCK,
    output logic [1:0]         hmsel
);

    localparam logic [IDX_W-1:0] DEF_IDX = IDX_W'(DEF_MST);

    arb_state_e          state_q, state_d;
    logic [NUM_MST-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]    gidx_q, gidx_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                lock_hold_q, lock_hold_d;
    logic [IDX_W-1:0]    hmaster_q, hmaster_d;
    logic                hmastlock_q, hmastlock_d;

    logic [IDX_W-1:0]    pick_start;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;
    logic [NUM_MST-1:0]  win_onehot;
    logic [NUM_MST-1:0]  def_onehot;
    logic                take_grant;
    logic                owner_lock;
    logic                rearb_pt;

    for (genvar gi = 0; gi < NUM_MST; gi++) begin : g_dec
        assign win_onehot[gi] = (pick_idx == IDX_W'(gi));
        assign def_onehot[gi] = (gi == DEF_MST);
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] last_q, last_d;

    assign pick_start = (last_q == IDX_W'(NUM_MST - 1)) ? '0 : last_q + 1'b1;
    assign last_d     = take_grant ? pick_idx : last_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            last_q <= DEF_IDX;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign pick_start = '0;
`endif

    ahb_arb_pick #(
        .NUM_MST (NUM_MST)
    ) u_pick (
        .req_i    (HBUSREQ),
        .start_i  (pick_start),
        .winner_o (pick_idx),
        .valid_o  (pick_valid)
    );

    assign owner_lock = HLOCK[gidx_q];

    // The grant may move while the last beat of a burst is in its address phase.
    assign rearb_pt = (beat_q == '0) ||
                      ((beat_q == BEAT_W'(1)) && (HTRANS == HTRANS_SEQ) && HREADY);

    always_comb begin
        beat_d = beat_q;
        if (HREADY) begin
            case (HTRANS)
                HTRANS_NONSEQ: beat_d = burst_beats(HBURST);
                HTRANS_SEQ:    beat_d = (beat_q != '0) ? beat_q - 1'b1 : beat_q;
                HTRANS_BUSY:   beat_d = beat_q;
                default:       beat_d = '0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        lock_hold_d = lock_hold_q;
        take_grant  = 1'b0;

        case (state_q)
            ST_PARK: begin
                if (pick_valid) begin
                    take_grant = 1'b1;
                    state_d    = ST_OWN;
                end
            end
            ST_OWN: begin
                if (rearb_pt && !lock_hold_q) begin
                    if (owner_lock) begin
                        state_d = ST_LOCK;
                    end else if (pick_valid) begin
                        take_grant = 1'b1;
                    end else begin
                        state_d = ST_PARK;
                        grant_d = def_onehot;
                        gidx_d  = DEF_IDX;
                    end
                end
            end
            ST_LOCK: begin
                // One more completed transfer after HLOCK drops before the bus can move.
                if (lock_hold_q) begin
                    if (HREADY) begin
                        lock_hold_d = 1'b0;
                        state_d     = ST_OWN;
                    end
                end else if (!owner_lock) begin
                    lock_hold_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_PARK;
                grant_d     = def_onehot;
                gidx_d      = DEF_IDX;
                lock_hold_d = 1'b0;
            end
        endcase

        if (take_grant) begin
            grant_d = win_onehot;
            gidx_d  = pick_idx;
        end
    end

    always_comb begin
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        if (HREADY) begin
            hmaster_d   = gidx_q;
            hmastlock_d = owner_lock;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_PARK;
            grant_q     <= def_onehot;
            gidx_q      <= DEF_IDX;
            beat_q      <= '0;
            lock_hold_q <= 1'b0;
            hmaster_q   <= DEF_IDX;
            hmastlock_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            beat_q      <= beat_d;
            lock_hold_q <= lock_hold_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
        end
    end

    assign HGRANT    = grant_q;
    assign HMASTER   = {{(4 - IDX_W){1'b0}}, hmaster_q};
    assign hmsel     = hmaster_q;
    assign HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter (default fixed-priority build): every change of
// {HGRANT, HMASTER, hmsel, HMASTLOCK} must match the next queued snapshot and its cycle.
module tb_ahb_bus_arbiter;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic [3:0] HBUSREQ;
    logic [3:0] HLOCK;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HREADY;
    logic [3:0] HGRANT;
    logic [3:0] HMASTER;
    logic       HMASTLOCK;
    logic [1:0] hmsel;

    ahb_bus_arbiter #(
        .NUM_MST (4),
        .DEF_MST (0)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HBUSREQ   (HBUSREQ),
        .HLOCK     (HLOCK),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HREADY    (HREADY),
        .HGRANT    (HGRANT),
        .HMASTER   (HMASTER),
        .HMASTLOCK (HMASTLOCK),
        .hmsel     (hmsel)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [10:0] snap;
        int          cyc;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    bit          mon_first = 1'b0;
    logic [10:0] prev_snap;
    logic [10:0] cur_snap;
    exp_t        got_e;
    int          c;

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Expected snapshot: grant, owner index (HMASTER and hmsel), lock, cycle it must appear in.
    task automatic expect_at(input string tag, input logic [3:0] g, input logic [1:0] m,
                             input logic lk, input int at);
        exp_t e;
        e.snap = {g, 2'b00, m, m, lk};
        e.cyc  = at;
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    always @(negedge HCLK) begin
        if (mon_en) begin
            cur_snap = {HGRANT, HMASTER, hmsel, HMASTLOCK};
            if (mon_first || cur_snap !== prev_snap) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got %h at cycle %0d, required no change",
                             cur_snap, cyc);
                end else begin
                    got_e = exp_q.pop_front();
                    if (cur_snap !== got_e.snap || cyc != got_e.cyc) begin
                        errors++;
                        $display("FAIL %s: got grant=%b master=%0d sel=%0d lock=%b at cycle %0d, required snap=%h at cycle %0d",
                                 got_e.tag, HGRANT, HMASTER, hmsel, HMASTLOCK, cyc,
                                 got_e.snap, got_e.cyc);
                    end else begin
                        $display("ok   %s: grant=%b master=%0d sel=%0d lock=%b cycle %0d",
                                 got_e.tag, HGRANT, HMASTER, hmsel, HMASTLOCK, cyc);
                    end
                end
            end
            prev_snap = cur_snap;
            mon_first = 1'b0;
        end
    end

    initial begin
        HRESET  = 1'b1;
        HBUSREQ = 4'b0000;
        HLOCK   = 4'b0000;
        HTRANS  = 2'd0;
        HBURST  = 3'd0;
        HREADY  = 1'b1;
        repeat (3) tick();

        // Reset values, then ten idle cycles with no activity.
        HRESET = 1'b0;
        expect_at("reset", 4'b0001, 2'd0, 1'b0, cyc);
        mon_first = 1'b1;
        mon_en    = 1'b1;
        repeat (10) tick();

        // Two simultaneous requests: lowest index wins, owner follows on the next HREADY edge.
        c = cyc;
        HBUSREQ = 4'b0110;
        expect_at("req_grant1",  4'b0010, 2'd0, 1'b0, c + 1);
        expect_at("req_master1", 4'b0010, 2'd1, 1'b0, c + 2);
        repeat (3) tick();

        // Master 2 takes the bus, runs INCR4; master 1 asks on beat 2.
        c = cyc;
        HBUSREQ = 4'b0100;
        expect_at("to_grant2",    4'b0100, 2'd1, 1'b0, c + 1);
        expect_at("to_master2",   4'b0100, 2'd2, 1'b0, c + 2);
        expect_at("incr4_grant1", 4'b0010, 2'd2, 1'b0, c + 6);
        expect_at("incr4_mst1",   4'b0010, 2'd1, 1'b0, c + 7);
        repeat (2) tick();
        HTRANS = 2'd2;
        HBURST = 3'd3;
        tick();
        HTRANS  = 2'd3;
        HBUSREQ = 4'b0110;
        repeat (3) tick();
        HTRANS = 2'd0;
        repeat (3) tick();

        // Handover under three wait states.
        c = cyc;
        HREADY  = 1'b0;
        HBUSREQ = 4'b0001;
        expect_at("wait_grant0",  4'b0001, 2'd1, 1'b0, c + 1);
        expect_at("wait_master0", 4'b0001, 2'd0, 1'b0, c + 4);
        repeat (3) tick();
        HREADY = 1'b1;
        repeat (3) tick();

        // Locked SINGLE transfers by master 0 while master 3 waits.
        c = cyc;
        HBUSREQ = 4'b1001;
        HLOCK   = 4'b0001;
        HTRANS  = 2'd2;
        HBURST  = 3'd0;
        expect_at("lock_on",      4'b0001, 2'd0, 1'b1, c + 1);
        expect_at("lock_off",     4'b0001, 2'd0, 1'b0, c + 6);
        expect_at("lock_grant3",  4'b1000, 2'd0, 1'b0, c + 8);
        expect_at("lock_master3", 4'b1000, 2'd3, 1'b0, c + 9);
        repeat (5) tick();
        HLOCK   = 4'b0000;
        HBUSREQ = 4'b1000;
        repeat (6) tick();

        // All four requesting SINGLE transfers: master 0 keeps the bus.
        c = cyc;
        HBUSREQ = 4'b1111;
        expect_at("all_grant0",  4'b0001, 2'd3, 1'b0, c + 1);
        expect_at("all_master0", 4'b0001, 2'd0, 1'b0, c + 2);
        repeat (10) tick();

        // Reset in the middle of a locked INCR16; no residual lock or beat count afterwards.
        c = cyc;
        HLOCK  = 4'b0001;
        HBURST = 3'd7;
        expect_at("burst_lock",   4'b0001, 2'd0, 1'b1, c + 1);
        expect_at("mid_reset",    4'b0001, 2'd0, 1'b0, c + 3);
        expect_at("post_grant2",  4'b0100, 2'd0, 1'b0, c + 4);
        expect_at("post_master2", 4'b0100, 2'd2, 1'b0, c + 5);
        expect_at("post_grant1",  4'b0010, 2'd2, 1'b0, c + 6);
        expect_at("post_master1", 4'b0010, 2'd1, 1'b0, c + 7);
        tick();
        HTRANS = 2'd3;
        tick();
        HRESET  = 1'b1;
        HLOCK   = 4'b0000;
        HBUSREQ = 4'b0100;
        tick();
        HRESET = 1'b0;
        repeat (2) tick();
        HBUSREQ = 4'b0010;
        repeat (3) tick();

        // No requests: park on the default master.
        c = cyc;
        HBUSREQ = 4'b0000;
        HTRANS  = 2'd0;
        expect_at("park_grant",  4'b0001, 2'd1, 1'b0, c + 1);
        expect_at("park_master", 4'b0001, 2'd0, 1'b0, c + 2);
        repeat (5) tick();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending: got %0d expected changes never seen, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
